asrv32_exit_monitor: RTL and testbench
======================================

// Module: asrv32_exit_monitor
// PURPOSE
//  Synthesizable run-control and exit-code monitor for the asrv32 SoC.
//  - Snoops core commit events: retiring instruction, base-register writes, data-memory writes.
//  - Detects end of test (ebreak/ecall, tohost write, PC limit, timeout) and latches a verdict per riscv-tests rules.
//  - Reports statistics; benches, FPGA LEDs or a debug UART read these instead of probing hierarchy.
// PARAMETERS
//  PC_LIMIT     32'h0000_07CC  PC at/above which execution counts as ran off end of program
//  TOHOST_ADDR  32'h0000_1000  byte address of tohost word
//  TIMEOUT      100000         max RUN cycles before TIMEOUT verdict; 0 disables timeout
//  CNT_W        32             width of cycle/retire/write counters
//  TRACE_DEPTH  16             trace buffer entries (power of 2, >=2); used only with trace macro
// PORTS
//  clk            in   1   core clock
//  rst_n          in   1   asynchronous active-low reset
//  i_clear        in   1   sync clear: verdict, counters, trace -> reset state
//  i_inst_valid   in   1   instruction retires this cycle
//  i_inst         in   32  retiring instruction word
//  i_pc           in   32  PC of retiring instruction
//  i_rf_wr_en     in   1   base-register write strobe
//  i_rf_wr_addr   in   5   base-register index
//  i_rf_wr_data   in   32  base-register write data
//  i_mem_wr_en    in   1   data-memory write strobe
//  i_mem_addr     in   32  data-memory byte address
//  i_mem_wr_data  in   32  data-memory write data
//  i_mem_wr_mask  in   4   byte-enable mask
//  o_done         out  1   verdict latched (sticky)
//  o_status       out  3   0 RUN, 1 PASS, 2 FAIL, 3 UNKNOWN, 4 TIMEOUT (7 IDLE)
//  o_exit_code    out  31  exit code (x10>>1 or tohost>>1)
//  o_cycles       out  CNT_W  cycles spent in RUN
//  o_retired      out  CNT_W  retired instructions
//  o_rf_writes    out  CNT_W  base-register writes, rd!=0
//  o_mem_writes   out  CNT_W  data-memory writes
//  i_trace_idx    in   $clog2(TRACE_DEPTH)  trace read index, 0 = newest
//  o_trace_entry  out  70  {valid,is_mem,mask[3:0],addr[31:0],data[31:0]}; reg entry addr = rd index
// BEHAVIOUR
//  - Reset/clear: state IDLE, o_status=7, o_done=0, counters/exit code 0, shadow x10/x17 = 0, trace invalid.
//  - FSM IDLE -> RUN on first i_inst_valid; that instruction is counted.
//  - RUN -> DONE when an exit condition fires; DONE -> IDLE only via rst_n or i_clear.
//  - Outputs registered: verdict visible cycle after triggering event.
//  - Counters advance only in RUN (and IDLE->RUN cycle); saturate at all-ones, no wrap.
//  - Shadow x10/x17 track every rf write. A write in same cycle as ebreak/ecall is forwarded into verdict.
//  - Exit conditions, priority high->low:
//    1 tohost: i_mem_wr_en & addr==TOHOST_ADDR & mask==4'hF & data[0]:
//      data==1 -> PASS, code 0; else FAIL, code data>>1. data[0]==0 -> no exit.
//    2 ebreak (32'h00100073) or ecall (32'h00000073) retiring:
//      x17==32'h5d & x10==0 -> PASS; x17==32'h5d & x10!=0 -> FAIL, code x10>>1; else UNKNOWN, code x10>>1.
//    3 retiring i_pc >= PC_LIMIT -> UNKNOWN, code 0.
//    4 TIMEOUT!=0 & o_cycles reaches TIMEOUT -> TIMEOUT, code 0.
//  - Exit and timeout in same cycle: exit wins.
//  - In DONE all inputs ignored: counters, shadows and trace frozen.
//  - rf writes with rd==0 are not counted, shadowed or traced.
//  - Async reset mid-run: immediate return to reset state; no partial verdict retained.
// CONFIGURATION
//  ASRV32_EXIT_MONITOR_TRACE_EN defined:
//    - TRACE_DEPTH-entry circular buffer of last writes; overwrites oldest when full.
//    - rf and mem write in same cycle: mem logged first, rf second (two slots, both kept).
//    - Trace recorded in RUN only; entries beyond fill level read valid=0.
//  Not defined: no buffer storage; o_trace_entry tied to 0; i_trace_idx unused.
// TESTING
//  1 x17<=0x5d, x10<=0, retire 0x00100073 -> next cycle o_done=1, o_status=1, o_exit_code=0.
//  2 x17<=0x5d, x10<=0x7, ebreak -> o_status=2, o_exit_code=0x3.
//    Repeat with x10 written same cycle as ebreak -> uses forwarded value.
//  3 Write 32'h0000_000B to TOHOST_ADDR, mask 4'hF -> FAIL, code 0x5.
//    Write 32'h2 -> no exit. Write 32'h1 same cycle as ebreak with x17=0 -> PASS (tohost priority).
//  4 TIMEOUT=50, no exit -> o_status=4 after 50 RUN cycles; o_cycles=50, frozen afterwards.
//  5 Retire at i_pc=PC_LIMIT -> UNKNOWN; assert i_clear -> o_status=7, counters 0.
//    Assert rst_n low mid-run -> same values immediately.
//  6 TRACE_EN, TRACE_DEPTH=4: 6 mem writes addr 0x1080+4k -> idx0=0x1094, idx3=0x1088.
//    rf+mem same cycle -> idx0 rf, idx1 mem.

Source files
------------

// File: rtl/asrv32_exit_monitor.sv
// Run-control / exit-code monitor for the asrv32 SoC: snoops commits, latches a riscv-tests verdict, keeps stats.
// Optional write-trace buffer enabled by defining ASRV32_EXIT_MONITOR_TRACE_EN.
module asrv32_exit_monitor #(
    parameter logic [31:0] PC_LIMIT    = 32'h0000_07CC,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int unsigned TIMEOUT     = 100000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TRACE_DEPTH = 16,
    localparam int unsigned IDX_W      = $clog2(TRACE_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inst_valid,
    input  logic [31:0]      i_inst,
    input  logic [31:0]      i_pc,
    input  logic             i_rf_wr_en,
    input  logic [4:0]       i_rf_wr_addr,
    input  logic [31:0]      i_rf_wr_data,
    input  logic             i_mem_wr_en,
    input  logic [31:0]      i_mem_addr,
    input  logic [31:0]      i_mem_wr_data,
    input  logic [3:0]       i_mem_wr_mask,
    output logic             o_done,
    output logic [2:0]       o_status,
    output logic [30:0]      o_exit_code,
    output logic [CNT_W-1:0] o_cycles,
    output logic [CNT_W-1:0] o_retired,
    output logic [CNT_W-1:0] o_rf_writes,
    output logic [CNT_W-1:0] o_mem_writes,
    input  logic [IDX_W-1:0] i_trace_idx,
    output logic [69:0]      o_trace_entry
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [2:0]       ST_RUN = 3'd0, ST_PASS = 3'd1, ST_FAIL = 3'd2;
    localparam logic [2:0]       ST_UNKNOWN = 3'd3, ST_TIMEOUT = 3'd4, ST_IDLE = 3'd7;
    localparam logic [31:0]      EBREAK = 32'h0010_0073;
    localparam logic [31:0]      ECALL  = 32'h0000_0073;
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

    state_e           state_q;
    logic             done_q;
    logic [2:0]       status_q, status_d;
    logic [30:0]      code_q, code_d;
    logic [31:0]      x10_q, x17_q, x10_fwd, x17_fwd;
    logic [CNT_W-1:0] cycles_q, retired_q, rf_writes_q, mem_writes_q;
    logic [CNT_W-1:0] cycles_d, retired_d, rf_writes_d, mem_writes_d;
    logic             active, rf_ok, is_sys, tohost_hit, pc_hit, timeout_hit, exit_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        active  = (state_q == S_RUN) || ((state_q == S_IDLE) && i_inst_valid);
        rf_ok   = i_rf_wr_en && (i_rf_wr_addr != 5'd0);
        // A same-cycle register write is visible to an ebreak/ecall retiring alongside it.
        x10_fwd = (rf_ok && (i_rf_wr_addr == 5'd10)) ? i_rf_wr_data : x10_q;
        x17_fwd = (rf_ok && (i_rf_wr_addr == 5'd17)) ? i_rf_wr_data : x17_q;
        is_sys      = i_inst_valid && ((i_inst == EBREAK) || (i_inst == ECALL));
        tohost_hit  = i_mem_wr_en && (i_mem_addr == TOHOST_ADDR) && (i_mem_wr_mask == 4'hF)
                      && i_mem_wr_data[0];
        pc_hit      = i_inst_valid && (i_pc >= PC_LIMIT);
        cycles_d     = sat_inc(cycles_q, 1'b1);
        retired_d    = sat_inc(retired_q, i_inst_valid);
        rf_writes_d  = sat_inc(rf_writes_q, rf_ok);
        mem_writes_d = sat_inc(mem_writes_q, i_mem_wr_en);
        timeout_hit  = TIMEOUT_EN && (cycles_d == TIMEOUT_C);

        exit_fire = 1'b1;
        status_d  = ST_RUN;
        code_d    = '0;
        if (tohost_hit) begin
            status_d = (i_mem_wr_data == 32'd1) ? ST_PASS : ST_FAIL;
            code_d   = i_mem_wr_data[31:1];
        end else if (is_sys) begin
            code_d = x10_fwd[31:1];
            if (x17_fwd == 32'h5d) status_d = (x10_fwd == 32'd0) ? ST_PASS : ST_FAIL;
            else                   status_d = ST_UNKNOWN;
        end else if (pc_hit) begin
            status_d = ST_UNKNOWN;
        end else if (timeout_hit) begin
            status_d = ST_TIMEOUT;
        end else begin
            exit_fire = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;  done_q <= 1'b0;  status_q <= ST_IDLE;  code_q <= '0;
            x10_q <= '0;  x17_q <= '0;
            cycles_q <= '0;  retired_q <= '0;  rf_writes_q <= '0;  mem_writes_q <= '0;
        end else if (i_clear) begin
            state_q <= S_IDLE;  done_q <= 1'b0;  status_q <= ST_IDLE;  code_q <= '0;
            x10_q <= '0;  x17_q <= '0;
            cycles_q <= '0;  retired_q <= '0;  rf_writes_q <= '0;  mem_writes_q <= '0;
        end else if (state_q != S_DONE) begin
            if (rf_ok && (i_rf_wr_addr == 5'd10)) x10_q <= i_rf_wr_data;
            if (rf_ok && (i_rf_wr_addr == 5'd17)) x17_q <= i_rf_wr_data;
            if (active) begin
                cycles_q     <= cycles_d;
                retired_q    <= retired_d;
                rf_writes_q  <= rf_writes_d;
                mem_writes_q <= mem_writes_d;
                if (exit_fire) begin
                    state_q  <= S_DONE;
                    done_q   <= 1'b1;
                    status_q <= status_d;
                    code_q   <= code_d;
                end else begin
                    state_q  <= S_RUN;
                    status_q <= ST_RUN;
                end
            end
        end
    end

    assign o_done       = done_q;
    assign o_status     = status_q;
    assign o_exit_code  = code_q;
    assign o_cycles     = cycles_q;
    assign o_retired    = retired_q;
    assign o_rf_writes  = rf_writes_q;
    assign o_mem_writes = mem_writes_q;

`ifdef ASRV32_EXIT_MONITOR_TRACE_EN
    localparam int unsigned FILL_W = IDX_W + 1;

    logic [68:0]       trace_mem [TRACE_DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d, rf_slot, rd_slot;
    logic [FILL_W-1:0] fill_q, fill_d, fill_sum;
    logic [69:0]       trace_entry_q;
    logic              mem_log, rf_log;
    logic [1:0]        n_log;

    always_comb begin
        mem_log  = active && i_mem_wr_en;
        rf_log   = active && rf_ok;
        n_log    = {1'b0, mem_log} + {1'b0, rf_log};
        // Memory write takes the first slot, so the register write ends up newest.
        rf_slot  = mem_log ? wr_ptr_q + IDX_W'(1) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q + IDX_W'(n_log);
        fill_sum = fill_q + FILL_W'(n_log);
        fill_d   = (fill_sum > FILL_W'(TRACE_DEPTH)) ? FILL_W'(TRACE_DEPTH) : fill_sum;
        rd_slot  = wr_ptr_q - IDX_W'(1) - i_trace_idx;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
            if (mem_log && (wr_ptr_q == IDX_W'(i)))
                trace_mem[i] <= {1'b1, i_mem_wr_mask, i_mem_addr, i_mem_wr_data};
            else if (rf_log && (rf_slot == IDX_W'(i)))
                trace_mem[i] <= {1'b0, 4'h0, 27'd0, i_rf_wr_addr, i_rf_wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;  fill_q <= '0;  trace_entry_q <= '0;
        end else if (i_clear) begin
            wr_ptr_q <= '0;  fill_q <= '0;  trace_entry_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            fill_q        <= fill_d;
            trace_entry_q <= ({1'b0, i_trace_idx} < fill_q) ? {1'b1, trace_mem[rd_slot]} : '0;
        end
    end

    assign o_trace_entry = trace_entry_q;
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^i_trace_idx;
    assign o_trace_entry    = '0;
`endif

endmodule

// File: tb/tb_asrv32_exit_monitor.sv
// Directed self-checking bench for asrv32_exit_monitor (TIMEOUT=50, TRACE_DEPTH=4).
module tb_asrv32_exit_monitor;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;

    logic        clk = 1'b0, rst_n, i_clear, i_inst_valid, i_rf_wr_en, i_mem_wr_en;
    logic [31:0] i_inst, i_pc, i_rf_wr_data, i_mem_addr, i_mem_wr_data;
    logic [4:0]  i_rf_wr_addr;
    logic [3:0]  i_mem_wr_mask;
    logic [1:0]  i_trace_idx;
    logic        o_done;
    logic [2:0]  o_status;
    logic [30:0] o_exit_code;
    logic [31:0] o_cycles, o_retired, o_rf_writes, o_mem_writes;
    logic [69:0] o_trace_entry;
    int          cmp_count = 0, err_count = 0;

    asrv32_exit_monitor #(.TIMEOUT(50), .CNT_W(32), .TRACE_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_inst_valid(i_inst_valid),
        .i_inst(i_inst), .i_pc(i_pc), .i_rf_wr_en(i_rf_wr_en), .i_rf_wr_addr(i_rf_wr_addr),
        .i_rf_wr_data(i_rf_wr_data), .i_mem_wr_en(i_mem_wr_en), .i_mem_addr(i_mem_addr),
        .i_mem_wr_data(i_mem_wr_data), .i_mem_wr_mask(i_mem_wr_mask), .o_done(o_done),
        .o_status(o_status), .o_exit_code(o_exit_code), .o_cycles(o_cycles),
        .o_retired(o_retired), .o_rf_writes(o_rf_writes), .o_mem_writes(o_mem_writes),
        .i_trace_idx(i_trace_idx), .o_trace_entry(o_trace_entry)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_clear = 0; i_inst_valid = 0; i_inst = '0; i_pc = '0;
        i_rf_wr_en = 0; i_rf_wr_addr = '0; i_rf_wr_data = '0;
        i_mem_wr_en = 0; i_mem_addr = '0; i_mem_wr_data = '0; i_mem_wr_mask = '0;
    endtask

    task automatic do_clear();
        i_clear = 1;
        tick();
        i_clear = 0;
    endtask

    task automatic retire(input logic [31:0] inst, input logic [31:0] pc, input logic rf_en,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic mem_en,
                          input logic [31:0] maddr, input logic [31:0] mdata, input logic [3:0] mask);
        i_inst_valid = 1; i_inst = inst; i_pc = pc;
        i_rf_wr_en = rf_en; i_rf_wr_addr = rd; i_rf_wr_data = rdata;
        i_mem_wr_en = mem_en; i_mem_addr = maddr; i_mem_wr_data = mdata; i_mem_wr_mask = mask;
        tick();
        idle_inputs();
        $display("retire pc=%h inst=%h -> status=%0d done=%0d code=%h", pc, inst, o_status, o_done, o_exit_code);
    endtask

    task automatic test_reset();
        rst_n = 0; i_trace_idx = '0; idle_inputs();
        #22;
        cmp_count++; if (o_status !== 3'd7) begin err_count++; $display("FAIL reset_status got=%0d want=7", o_status); end
        cmp_count++; if (o_done !== 1'b0) begin err_count++; $display("FAIL reset_done got=%0d want=0", o_done); end
        cmp_count++; if ({o_cycles, o_retired, o_rf_writes, o_mem_writes} !== 128'd0) begin err_count++; $display("FAIL reset_counters got=%h/%h/%h/%h want=0", o_cycles, o_retired, o_rf_writes, o_mem_writes); end
        cmp_count++; if (o_exit_code !== 31'd0) begin err_count++; $display("FAIL reset_code got=%h want=0", o_exit_code); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_ebreak_pass();
        do_clear();
        retire(NOP, 32'h100, 1, 5'd17, 32'h5d, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd0 || o_done !== 1'b0) begin err_count++; $display("FAIL t1_run got=%0d/%0d want=0/0", o_status, o_done); end
        retire(NOP, 32'h104, 1, 5'd10, 32'h0, 0, '0, '0, 4'h0);
        retire(EBREAK, 32'h108, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd1 || o_done !== 1'b1) begin err_count++; $display("FAIL t1_pass got=%0d/%0d want=1/1", o_status, o_done); end
        cmp_count++; if (o_exit_code !== 31'd0) begin err_count++; $display("FAIL t1_code got=%h want=0", o_exit_code); end
        cmp_count++; if (o_cycles !== 32'd3 || o_retired !== 32'd3 || o_rf_writes !== 32'd2 || o_mem_writes !== 32'd0) begin err_count++; $display("FAIL t1_counts got=%0d/%0d/%0d/%0d want=3/3/2/0", o_cycles, o_retired, o_rf_writes, o_mem_writes); end
    endtask

    task automatic test_ebreak_fail();
        do_clear();
        retire(NOP, 32'h100, 1, 5'd17, 32'h5d, 0, '0, '0, 4'h0);
        retire(NOP, 32'h104, 1, 5'd10, 32'h7, 0, '0, '0, 4'h0);
        retire(EBREAK, 32'h108, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd2 || o_exit_code !== 31'h3) begin err_count++; $display("FAIL t2_fail got=%0d/%h want=2/3", o_status, o_exit_code); end
        // Inputs after the verdict must leave everything frozen.
        retire(NOP, 32'h10c, 1, 5'd10, 32'h0, 1, 32'h1000, 32'h1, 4'hF);
        retire(EBREAK, 32'h110, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd2 || o_exit_code !== 31'h3) begin err_count++; $display("FAIL t2_frozen_verdict got=%0d/%h want=2/3", o_status, o_exit_code); end
        cmp_count++; if (o_retired !== 32'd3 || o_rf_writes !== 32'd2 || o_mem_writes !== 32'd0 || o_cycles !== 32'd3) begin err_count++; $display("FAIL t2_frozen_counts got=%0d/%0d/%0d/%0d want=3/2/0/3", o_retired, o_rf_writes, o_mem_writes, o_cycles); end
        do_clear();
        retire(NOP, 32'h100, 1, 5'd17, 32'h5d, 0, '0, '0, 4'h0);
        retire(NOP, 32'h104, 1, 5'd10, 32'h0, 0, '0, '0, 4'h0);
        retire(EBREAK, 32'h108, 1, 5'd10, 32'h9, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd2 || o_exit_code !== 31'h4) begin err_count++; $display("FAIL t2_forward got=%0d/%h want=2/4", o_status, o_exit_code); end
        cmp_count++; if (o_rf_writes !== 32'd3) begin err_count++; $display("FAIL t2_fwd_rfw got=%0d want=3", o_rf_writes); end
        do_clear();
        retire(NOP, 32'h100, 1, 5'd10, 32'h14, 0, '0, '0, 4'h0);
        retire(ECALL, 32'h104, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd3 || o_exit_code !== 31'hA) begin err_count++; $display("FAIL t2_ecall_unknown got=%0d/%h want=3/a", o_status, o_exit_code); end
    endtask

    task automatic test_tohost();
        do_clear();
        retire(NOP, 32'h100, 0, 5'd0, '0, 1, 32'h1000, 32'hB, 4'hF);
        cmp_count++; if (o_status !== 3'd2 || o_exit_code !== 31'h5 || o_done !== 1'b1) begin err_count++; $display("FAIL t3_fail got=%0d/%h/%0d want=2/5/1", o_status, o_exit_code, o_done); end
        cmp_count++; if (o_mem_writes !== 32'd1) begin err_count++; $display("FAIL t3_memw got=%0d want=1", o_mem_writes); end
        do_clear();
        retire(NOP, 32'h100, 0, 5'd0, '0, 1, 32'h1000, 32'h2, 4'hF);
        cmp_count++; if (o_status !== 3'd0 || o_done !== 1'b0) begin err_count++; $display("FAIL t3_even got=%0d/%0d want=0/0", o_status, o_done); end
        retire(NOP, 32'h104, 0, 5'd0, '0, 1, 32'h1000, 32'hB, 4'h3);
        cmp_count++; if (o_status !== 3'd0 || o_done !== 1'b0) begin err_count++; $display("FAIL t3_partial_mask got=%0d/%0d want=0/0", o_status, o_done); end
        retire(EBREAK, 32'h108, 0, 5'd0, '0, 1, 32'h1000, 32'h1, 4'hF);
        cmp_count++; if (o_status !== 3'd1 || o_exit_code !== 31'd0) begin err_count++; $display("FAIL t3_priority got=%0d/%h want=1/0", o_status, o_exit_code); end
        cmp_count++; if (o_mem_writes !== 32'd3) begin err_count++; $display("FAIL t3_memw3 got=%0d want=3", o_mem_writes); end
    endtask

    task automatic test_timeout();
        do_clear();
        retire(NOP, 32'h100, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        for (int i = 0; i < 48; i++) tick();
        cmp_count++; if (o_status !== 3'd0 || o_cycles !== 32'd49) begin err_count++; $display("FAIL t4_before got=%0d/%0d want=0/49", o_status, o_cycles); end
        tick();
        cmp_count++; if (o_status !== 3'd4 || o_done !== 1'b1 || o_cycles !== 32'd50) begin err_count++; $display("FAIL t4_timeout got=%0d/%0d/%0d want=4/1/50", o_status, o_done, o_cycles); end
        for (int i = 0; i < 5; i++) tick();
        cmp_count++; if (o_cycles !== 32'd50 || o_retired !== 32'd1) begin err_count++; $display("FAIL t4_frozen got=%0d/%0d want=50/1", o_cycles, o_retired); end
        do_clear();
        retire(NOP, 32'h100, 1, 5'd17, 32'h5d, 0, '0, '0, 4'h0);
        for (int i = 0; i < 48; i++) tick();
        retire(EBREAK, 32'h104, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd1 || o_cycles !== 32'd50) begin err_count++; $display("FAIL t4_exit_wins got=%0d/%0d want=1/50", o_status, o_cycles); end
    endtask

    task automatic test_pc_limit();
        do_clear();
        retire(NOP, 32'h7C8, 1, 5'd10, 32'h22, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd0) begin err_count++; $display("FAIL t5_below got=%0d want=0", o_status); end
        retire(NOP, 32'h7CC, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd3 || o_exit_code !== 31'd0) begin err_count++; $display("FAIL t5_limit got=%0d/%h want=3/0", o_status, o_exit_code); end
        do_clear();
        cmp_count++; if (o_status !== 3'd7 || o_done !== 1'b0 || o_cycles !== 32'd0 || o_retired !== 32'd0 || o_rf_writes !== 32'd0) begin err_count++; $display("FAIL t5_clear got=%0d/%0d/%0d/%0d/%0d want=7/0/0/0/0", o_status, o_done, o_cycles, o_retired, o_rf_writes); end
        retire(NOP, 32'h7C0, 1, 5'd17, 32'h5d, 0, '0, '0, 4'h0);
        retire(EBREAK, 32'h800, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd1) begin err_count++; $display("FAIL t5_ebreak_over_pc got=%0d want=1", o_status); end
        do_clear();
        retire(NOP, 32'h100, 1, 5'd10, 32'h8, 1, 32'h2000, 32'h3, 4'hF);
        retire(NOP, 32'h104, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        #2 rst_n = 0;
        #1;
        cmp_count++; if (o_status !== 3'd7 || o_done !== 1'b0 || o_cycles !== 32'd0 || o_mem_writes !== 32'd0 || o_exit_code !== 31'd0) begin err_count++; $display("FAIL t5_async_rst got=%0d/%0d/%0d/%0d/%h want=7/0/0/0/0", o_status, o_done, o_cycles, o_mem_writes, o_exit_code); end
        #2 rst_n = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        do_clear();
        retire(NOP, 32'h100, 1, 5'd0, 32'h5d, 0, '0, '0, 4'h0);
        cmp_count++; if (o_rf_writes !== 32'd0 || o_retired !== 32'd1) begin err_count++; $display("FAIL bb_x0 got=%0d/%0d want=0/1", o_rf_writes, o_retired); end
        retire(NOP, 32'h104, 1, 5'd17, 32'h5d, 1, 32'h2000, 32'h1, 4'hF);
        retire(NOP, 32'h108, 1, 5'd0, 32'h1, 0, '0, '0, 4'h0);
        retire(EBREAK, 32'h10c, 0, 5'd0, '0, 0, '0, '0, 4'h0);
        cmp_count++; if (o_status !== 3'd1 || o_retired !== 32'd4 || o_rf_writes !== 32'd1 || o_mem_writes !== 32'd1) begin err_count++; $display("FAIL bb_counts got=%0d/%0d/%0d/%0d want=1/4/1/1", o_status, o_retired, o_rf_writes, o_mem_writes); end
    endtask

    task automatic test_trace();
`ifdef ASRV32_EXIT_MONITOR_TRACE_EN
        do_clear();
        for (int k = 0; k < 6; k++)
            retire(NOP, 32'h100 + 32'(4 * k), 0, 5'd0, '0, 1, 32'h1080 + 32'(4 * k), 32'(k), 4'hF);
        i_trace_idx = 2'd0; tick();
        cmp_count++; if (o_trace_entry[69:68] !== 2'b11 || o_trace_entry[63:32] !== 32'h1094) begin err_count++; $display("FAIL t6_idx0 got=%b/%h want=11/1094", o_trace_entry[69:68], o_trace_entry[63:32]); end
        i_trace_idx = 2'd3; tick();
        cmp_count++; if (o_trace_entry[69] !== 1'b1 || o_trace_entry[63:32] !== 32'h1088) begin err_count++; $display("FAIL t6_idx3 got=%b/%h want=1/1088", o_trace_entry[69], o_trace_entry[63:32]); end
        do_clear();
        retire(NOP, 32'h100, 1, 5'd5, 32'hAA, 1, 32'h1080, 32'h55, 4'hF);
        i_trace_idx = 2'd0; tick();
        cmp_count++; if (o_trace_entry[69:68] !== 2'b10 || o_trace_entry[63:32] !== 32'd5 || o_trace_entry[31:0] !== 32'hAA) begin err_count++; $display("FAIL t6_rf_newest got=%b/%h/%h want=10/5/aa", o_trace_entry[69:68], o_trace_entry[63:32], o_trace_entry[31:0]); end
        i_trace_idx = 2'd1; tick();
        cmp_count++; if (o_trace_entry[69:68] !== 2'b11 || o_trace_entry[63:32] !== 32'h1080) begin err_count++; $display("FAIL t6_mem_second got=%b/%h want=11/1080", o_trace_entry[69:68], o_trace_entry[63:32]); end
        i_trace_idx = 2'd2; tick();
        cmp_count++; if (o_trace_entry[69] !== 1'b0) begin err_count++; $display("FAIL t6_beyond_fill got=%b want=0", o_trace_entry[69]); end
`else
        do_clear();
        retire(NOP, 32'h100, 1, 5'd5, 32'hAA, 1, 32'h1080, 32'h55, 4'hF);
        i_trace_idx = 2'd0; tick();
        cmp_count++; if (o_trace_entry !== 70'd0) begin err_count++; $display("FAIL trace_disabled got=%h want=0", o_trace_entry); end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ebreak_pass();
        test_ebreak_fail();
        test_tohost();
        test_timeout();
        test_pc_limit();
        test_back_to_back();
        test_trace();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule
